fir_seq: RTL and testbench

Frame sequencer for the unrolled FIR datapath (`dpath`, UNR samples/word, 37 taps). It synchronises the asynchronous start request, pulls input words from the sample FIFO, drives the datapath `EN`, and tracks pipeline occupancy so `OUT_VALID` lines up with `firsum`. It also stalls the whole pipeline on output backpressure, drains it at end of frame, and swaps the active coefficient bank only between frames.

---
 rtl/fir_pkg.sv | 16 +
 rtl/start_sync.sv | 32 +++
 rtl/fir_seq.sv | 123 ++++++++++++
 tb/tb_fir_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR frame sequencer
package fir_pkg;

    localparam int FIR_NTAP = 37;
    localparam int FIR_UNR  = 4;
    localparam int FIR_LAT  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        DRAIN,
        FINISH
    } fir_state_t;

endpackage

// File: rtl/start_sync.sv
// rtl/start_sync.sv - start request synchroniser with rising-edge detect
module start_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic start_pulse_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic [1:0] settle_q;
    logic       prev_low_q;

    // Two-flop synchroniser; the edge detector only arms once the chain holds a
    // real sample, so a level already high across reset never reads as an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            settle_q   <= 2'b00;
            prev_low_q <= 1'b0;
        end else begin
            sync1_q    <= async_i;
            sync2_q    <= sync1_q;
            settle_q   <= {settle_q[0], 1'b1};
            prev_low_q <= settle_q[1] & ~sync2_q;
        end
    end

    assign start_pulse_o = sync2_q & prev_low_q;

endmodule

// File: rtl/fir_seq.sv
// rtl/fir_seq.sv - frame sequencer for the unrolled FIR datapath
module fir_seq
    import fir_pkg::*;
#(
    parameter int UNR  = FIR_UNR,
    parameter int LAT  = FIR_LAT,
    parameter int LENW = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ASYNC_START,
    input  logic [LENW-1:0] DLEN,
    input  logic            COEF_SEL_REQ,
    input  logic            FIFO_VALID,
    output logic            FIFO_RD,
    output logic            EN,
    input  logic            OUT_READY,
    output logic            OUT_VALID,
    output logic            SYNC_READY,
    output logic            COEF_SEL,
    output logic            BUSY,
    output logic            DONE
);

    // Unroll factor only shapes the datapath; counting here is per word.
    if (UNR < 1 || UNR > FIR_NTAP) begin : g_unr_out_of_range
    end

    fir_state_t      state_q, state_d;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] rd_cnt_q, rd_cnt_d;
    logic [LENW-1:0] out_cnt_q, out_cnt_d;
    logic [LAT-1:0]  vsr_q, vsr_d;
    logic            coef_sel_q;
    logic            busy_q;
    logic            done_q;
    logic            start_pulse;
    logic            fifo_rd;
    logic            en;
    logic            out_take;

    start_sync u_start_sync (
        .clk_i         (CLK),
        .rst_i         (RST),
        .async_i       (ASYNC_START),
        .start_pulse_o (start_pulse)
    );

    // A word leaves the pipeline only when it advances; a word parked at the
    // output during an input bubble is therefore counted once.
    assign out_take  = vsr_q[LAT-1] & en;
    assign rd_cnt_d  = fifo_rd  ? rd_cnt_q + LENW'(1)  : rd_cnt_q;
    assign out_cnt_d = out_take ? out_cnt_q + LENW'(1) : out_cnt_q;
    assign vsr_d     = en ? {vsr_q[LAT-2:0], fifo_rd} : vsr_q;

    // Next state plus pop/advance strobes; OUT_READY low freezes everything.
    always_comb begin
        state_d = state_q;
        fifo_rd = 1'b0;
        en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_pulse) state_d = ARM;
            end
            ARM: begin
                state_d = (DLEN == '0) ? FINISH : RUN;
            end
            RUN: begin
                fifo_rd = FIFO_VALID & OUT_READY;
                en      = fifo_rd;
                if (fifo_rd && rd_cnt_d == len_q) state_d = DRAIN;
            end
            DRAIN: begin
                en = OUT_READY & (|vsr_q);
                if (out_cnt_d == len_q) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, valid shift register and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            vsr_q      <= '0;
            coef_sel_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == FINISH);
            if (state_q == ARM) begin
                len_q      <= DLEN;
                rd_cnt_q   <= '0;
                out_cnt_q  <= '0;
                vsr_q      <= '0;
                coef_sel_q <= COEF_SEL_REQ;
            end else begin
                rd_cnt_q  <= rd_cnt_d;
                out_cnt_q <= out_cnt_d;
                vsr_q     <= vsr_d;
            end
        end
    end

    assign FIFO_RD    = fifo_rd;
    assign EN         = en;
    assign OUT_VALID  = vsr_q[LAT-1];
    assign SYNC_READY = (state_q == RUN);
    assign COEF_SEL   = coef_sel_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_fir_seq.sv
// tb/tb_fir_seq.sv - directed self-checking bench for fir_seq
module tb_fir_seq;

    localparam int LENW = 32;

    logic            CLK;
    logic            RST;
    logic            ASYNC_START;
    logic [LENW-1:0] DLEN;
    logic            COEF_SEL_REQ;
    logic            FIFO_VALID;
    logic            FIFO_RD;
    logic            EN;
    logic            OUT_READY;
    logic            OUT_VALID;
    logic            SYNC_READY;
    logic            COEF_SEL;
    logic            BUSY;
    logic            DONE;

    int n_checks = 0;
    int n_errors = 0;

    int n_pops, first_pop, last_pop;
    int n_takes, first_take;
    int n_ov, first_ov, last_ov;
    int n_en, en_low_run, bp_viol, ov_hold_viol;
    int done_cyc, n_done, run_start, coef_bad, outcnt_at_done, busy_at_run;
    int pops, busy_cnt;

    fir_seq #(.UNR(4), .LAT(4), .LENW(LENW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ASYNC_START  (ASYNC_START),
        .DLEN         (DLEN),
        .COEF_SEL_REQ (COEF_SEL_REQ),
        .FIFO_VALID   (FIFO_VALID),
        .FIFO_RD      (FIFO_RD),
        .EN           (EN),
        .OUT_READY    (OUT_READY),
        .OUT_VALID    (OUT_VALID),
        .SYNC_READY   (SYNC_READY),
        .COEF_SEL     (COEF_SEL),
        .BUSY         (BUSY),
        .DONE         (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One frame: start is raised in cycle 0; masks are relative to the first RUN cycle.
    task automatic run_frame(input int len, input bit creq, input int ctog,
                             input int fv_s, input int fv_n,
                             input int r1_s, input int r1_n,
                             input int r2_s, input int r2_n);
        int rel;
        logic prev_rdy, prev_ov;
        n_pops = 0; first_pop = -1; last_pop = -1;
        n_takes = 0; first_take = -1;
        n_ov = 0; first_ov = -1; last_ov = -1;
        n_en = 0; en_low_run = 0; bp_viol = 0; ov_hold_viol = 0;
        done_cyc = -1; n_done = 0; run_start = -1; coef_bad = 0;
        outcnt_at_done = -1; busy_at_run = -1;
        DLEN = len; COEF_SEL_REQ = creq; FIFO_VALID = 1'b1; OUT_READY = 1'b1;
        @(posedge CLK); #1 ASYNC_START = 1'b0;
        repeat (4) @(posedge CLK);
        prev_rdy = 1'b1; prev_ov = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK); #1;
            if (i == 0) ASYNC_START = 1'b1;
            if (SYNC_READY && run_start < 0) begin
                run_start = i;
                busy_at_run = BUSY;
            end
            rel = (run_start >= 0) ? i - run_start : -1;
            FIFO_VALID = !(rel >= fv_s && rel < fv_s + fv_n);
            OUT_READY  = !((rel >= r1_s && rel < r1_s + r1_n) ||
                           (rel >= r2_s && rel < r2_s + r2_n));
            if (ctog >= 0 && rel == ctog) COEF_SEL_REQ = !creq;
            #1;
            if (FIFO_RD) begin
                n_pops++; last_pop = i;
                if (first_pop < 0) first_pop = i;
            end
            if (OUT_VALID) begin
                n_ov++; last_ov = i;
                if (first_ov < 0) first_ov = i;
            end
            if (OUT_VALID && OUT_READY && EN) begin
                n_takes++;
                if (first_take < 0) first_take = i;
            end
            if (EN) n_en++;
            if (SYNC_READY && !EN) en_low_run++;
            if (SYNC_READY && COEF_SEL !== creq) coef_bad++;
            if (!OUT_READY && (FIFO_RD || EN)) bp_viol++;
            if (!prev_rdy && OUT_VALID !== prev_ov) ov_hold_viol++;
            prev_rdy = OUT_READY; prev_ov = OUT_VALID;
            if (DONE) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = i;
                    outcnt_at_done = int'(dut.out_cnt_q);
                end
            end
            if (done_cyc >= 0 && i >= done_cyc + 3) break;
        end
        ASYNC_START = 1'b0;
    endtask

    initial begin
        RST = 1'b1; ASYNC_START = 1'b0; DLEN = '0; COEF_SEL_REQ = 1'b0;
        FIFO_VALID = 1'b0; OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", {FIFO_RD, EN, OUT_VALID, SYNC_READY, COEF_SEL, BUSY, DONE}, 0);
        #3 RST = 1'b0;

        // Basic frame, coefficient request toggled mid-frame
        run_frame(10, 1'b1, 3, 0, 0, 0, 0, 0, 0);
        check("basic_run_entry", run_start, 4);
        check("basic_busy_in_run", busy_at_run, 1);
        check("basic_pops", n_pops, 10);
        check("basic_pop_span", last_pop - first_pop, 9);
        check("basic_first_valid_lat", first_ov - first_pop, 4);
        check("basic_valid_cycles", n_ov, 10);
        check("basic_valid_span", last_ov - first_ov, 9);
        check("basic_takes", n_takes, 10);
        check("basic_done_lat", done_cyc - last_pop, 5);
        check("basic_done_pulses", n_done, 1);
        check("coef_stable_in_frame", coef_bad, 0);
        check("coef_after_frame", COEF_SEL, 1);
        check("basic_idle_busy", BUSY, 0);

        // FIFO underflow after the 4th pop
        run_frame(8, 1'b1, -1, 4, 3, 0, 0, 0, 0);
        check("uflow_pops", n_pops, 8);
        check("uflow_en_low", en_low_run, 3);
        check("uflow_takes", n_takes, 8);
        check("uflow_first_valid_lat", first_ov - first_pop, 4);
        check("uflow_first_take_lat", first_take - first_pop, 7);
        check("uflow_done_lat", done_cyc - last_pop, 5);
        check("uflow_done_pulses", n_done, 1);

        // Backpressure: 5 cycles mid-RUN, 2 cycles in DRAIN; new frame takes bank 0
        run_frame(12, 1'b0, -1, 0, 0, 5, 5, 18, 2);
        check("bp_pops", n_pops, 12);
        check("bp_pop_span", last_pop - first_pop, 16);
        check("bp_no_move_when_low", bp_viol, 0);
        check("bp_valid_hold", ov_hold_viol, 0);
        check("bp_takes", n_takes, 12);
        check("bp_outcnt_at_done", outcnt_at_done, 12);
        check("bp_done_lat", done_cyc - last_pop, 7);
        check("coef_next_frame", COEF_SEL, 0);

        // Zero length frame
        run_frame(0, 1'b1, -1, 0, 0, 0, 0, 0, 0);
        check("zero_pops", n_pops, 0);
        check("zero_en", n_en, 0);
        check("zero_valid", n_ov, 0);
        check("zero_no_run", run_start, -1);
        check("zero_done_cycle", done_cyc, 4);
        check("zero_done_pulses", n_done, 1);
        check("zero_coef", COEF_SEL, 1);

        // Reset mid-RUN with start held high
        DLEN = 20; COEF_SEL_REQ = 1'b1; FIFO_VALID = 1'b1; OUT_READY = 1'b1;
        @(posedge CLK); #1 ASYNC_START = 1'b0;
        repeat (4) @(posedge CLK);
        #1 ASYNC_START = 1'b1;
        pops = 0;
        for (int i = 0; i < 60 && pops < 5; i++) begin
            @(posedge CLK); #2;
            if (FIFO_RD) pops++;
        end
        check("rst_pops_before", pops, 5);
        @(posedge CLK); #1 RST = 1'b1; #1;
        check("rst_outputs_clear", {FIFO_RD, EN, OUT_VALID, SYNC_READY, COEF_SEL, BUSY, DONE}, 0);
        #3 RST = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (BUSY || SYNC_READY) busy_cnt++;
        end
        check("rst_no_restart_on_level", busy_cnt, 0);

        run_frame(4, 1'b0, -1, 0, 0, 0, 0, 0, 0);
        check("restart_pops", n_pops, 4);
        check("restart_takes", n_takes, 4);
        check("restart_done_lat", done_cyc - last_pop, 5);
        check("restart_done_pulses", n_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
